m_regfile_wb_arbiter: RTL

M_REGFILE_WB_ARBITER -- requirements
Module: m_regfile_wb_arbiter

---
 rtl/m_rfarb_pkg.sv | 14 +
 rtl/m_regfile_wb_arbiter_if.sv | 38 +++
 rtl/m_rfarb_fifo.sv | 80 ++++++++
 rtl/m_regfile_wb_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/m_rfarb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The queued entry is a destination register plus its write data.
package m_rfarb_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } rf_entry_t;

endpackage

// File: rtl/m_regfile_wb_arbiter_if.sv
// Bus bundle between two write requesters, the register file port and status outputs.
// The master modport is the requester/observer side; the slave modport is the arbiter.
interface m_regfile_wb_arbiter_if;
  import m_rfarb_pkg::*;

  logic                  req0_valid;
  logic [REG_ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0]     req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [REG_ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0]     req1_data;
  logic                  req1_ready;
  logic                  wb_hold;
  logic [REG_ADDR_W-1:0] rf_a2;
  logic                  rf_we;
  logic [DATA_W-1:0]     rf_wd;
  logic [31:0]           pending_mask;
  logic                  full;
  logic                  empty;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output wb_hold,
    input  req0_ready, req1_ready,
    input  rf_a2, rf_we, rf_wd, pending_mask, full, empty
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  wb_hold,
    output req0_ready, req1_ready,
    output rf_a2, rf_we, rf_wd, pending_mask, full, empty
  );

endinterface

// File: rtl/m_rfarb_fifo.sv
// Write queue for the arbiter: count-tracked circular buffer with head read-out
// and a per-slot occupancy view so the top can build the pending-register mask.
module m_rfarb_fifo
  import m_rfarb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  rf_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output rf_entry_t             head,
  output logic [REG_ADDR_W-1:0] slot_addr [DEPTH],
  output logic [DEPTH-1:0]      slot_valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  rf_entry_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    slot_off [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset; occupancy is defined solely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i]   = PW'(i) - rd_ptr_q;
      slot_valid[i] = (CW'(slot_off[i]) < count_q);
      slot_addr[i]  = mem[i].addr;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/m_regfile_wb_arbiter.sv
// Two-port round-robin write-back arbiter feeding a register file through an ordered queue.
// Optional build macro RFARB_DROP_X0_EN acknowledges writes to x0 without enqueuing them.
module m_regfile_wb_arbiter
  import m_rfarb_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input logic                   clk,
  input logic                   reset,
  m_regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  last_q, last_d;  // 1: port 1 was granted last
  logic                  grant1;
  logic                  commit;
  logic                  room;
  logic                  accept_ok;
  logic                  drop;
  logic                  xfer;
  logic                  push;
  rf_entry_t             sel_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  rf_entry_t             fifo_head;
  logic [REG_ADDR_W-1:0] slot_addr [DEPTH];
  logic [DEPTH-1:0]      slot_valid;

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant1 = !last_q;
    end else begin
      grant1 = bus.req1_valid;
    end
  end

  assign sel_entry = grant1 ? '{addr: bus.req1_addr, data: bus.req1_data}
                            : '{addr: bus.req0_addr, data: bus.req0_data};

  assign commit = !reset && !fifo_empty && !bus.wb_hold;
  // A commit this cycle frees the head slot, so a full queue can still take one write.
  assign room   = !fifo_full || commit;

`ifdef RFARB_DROP_X0_EN
  assign drop = (sel_entry.addr == '0);
`else
  assign drop = 1'b0;
`endif

  assign accept_ok      = room || drop;
  assign bus.req0_ready = !reset && !grant1 && accept_ok;
  assign bus.req1_ready = !reset && grant1 && accept_ok;

  assign xfer = (bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready);
  assign push = xfer && !drop;

  always_comb begin
    last_d = last_q;
    if (xfer) begin
      last_d = grant1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  m_rfarb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(sel_entry),
    .pop       (commit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head),
    .slot_addr (slot_addr),
    .slot_valid(slot_valid)
  );

  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        bus.pending_mask[slot_addr[i]] = 1'b1;
      end
    end
  end

  assign bus.rf_we = commit;
  assign bus.rf_a2 = fifo_empty ? '0 : fifo_head.addr;
  assign bus.rf_wd = fifo_empty ? '0 : fifo_head.data;
  assign bus.full  = fifo_full;
  assign bus.empty = fifo_empty;

  count_in_range: assert property (@(posedge clk) disable iff (reset) fifo_count <= CW'(DEPTH));

endmodule
